// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Binary select to one-hot grant.
  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin pick: first set request bit searching ptr, ptr+1, ... mod 4.
// Purely combinational; rotates so ptr lands at bit 0, priority-encodes the
// lowest set bit, then rotates the index back.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   pos;

  assign dbl   = {req, req} >> ptr;
  assign rot   = dbl[N_REQ-1:0];
  assign found = |req;

  // Lowest set bit of the rotated vector, mapped back to a requester index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pos = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = SEL_W'(i);
    end
    idx = pos + ptr;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner for the shared 4:1 single-bit mux. Issues a registered
// one-hot grant and the matching mux select, holds the owner while its
// request stays high (bounded by MAX_HOLD), and forces one idle cycle between
// consecutive owners so the mux output never swaps between two live owners.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] grant_n;
  logic [SEL_W-1:0] select_n;
  logic             busy_n;
  logic             timeout_n;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             at_limit;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // select always names the current owner while in GRANT.
  assign owner_req = req[select];
  assign at_limit  = (cnt == HOLD_LIM);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    grant_n   = grant;
    select_n  = select;
    busy_n    = busy;
    timeout_n = 1'b0;

    unique case (state)
      IDLE, GAP: begin
        if (pick_found) begin
          state_n  = GRANT;
          grant_n  = onehot4(pick_idx);
          select_n = pick_idx;
          busy_n   = 1'b1;
          cnt_n    = CNT_W'(1);
        end else begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
        end
      end

      GRANT: begin
        // Hitting the tenure limit wins over a plain release, so a release on
        // the last allowed cycle still reports timeout.
        if (at_limit || !owner_req) begin
          state_n   = GAP;
          grant_n   = '0;
          busy_n    = 1'b0;
          ptr_n     = select + SEL_W'(1);
          timeout_n = at_limit;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      select  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      grant   <= grant_n;
      select  <= select_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a per-cycle vector table on the default
// build, plus short sequences on MAX_HOLD=2 and MAX_HOLD=1 builds.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req16 = '0, req2 = '0, req1 = '0;
  logic [3:0] grant16, grant2, grant1;
  logic [1:0] sel16, sel2, sel1;
  logic       busy16, busy2, busy1;
  logic       tmo16, tmo2, tmo1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .req(req16),
    .grant(grant16), .select(sel16), .busy(busy16), .timeout(tmo16));

  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .req(req2),
    .grant(grant2), .select(sel2), .busy(busy2), .timeout(tmo2));

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .grant(grant1), .select(sel1), .busy(busy1), .timeout(tmo1));

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are looked at 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req16 = '0; req2 = '0; req1 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check16(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    check({tag, ".grant"},   8'(grant16), 8'(g));
    check({tag, ".select"},  8'(sel16),   8'(s));
    check({tag, ".busy"},    8'(busy16),  8'(b));
    check({tag, ".timeout"}, 8'(tmo16),   8'(t));
  endtask

  initial begin
    logic [3:0] exp2 [13];
    logic [1:0] exps2 [13];

    // {req before edge, grant, select, busy, timeout after edge}
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // single requester 2
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // gap, ptr=3
    vecs[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // idle, select held
    vecs[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // owner 2 again
    vecs[7]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0}; // no preemption
    vecs[8]  = '{4'b0001, 4'b0000, 2'd2, 1'b0, 1'b0}; // owner 2 drops, ptr=3
    vecs[9]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0}; // search 3,0 -> 0
    vecs[10] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0}; // 3 waits
    vecs[11] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0}; // release, ptr=1
    vecs[13] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0}; // search 1,2,3 -> 3
    vecs[14] = '{4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[15] = '{4'b0010, 4'b0000, 2'd3, 1'b0, 1'b0}; // release, ptr=0
    vecs[16] = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0}; // search 0,1 -> 1
    vecs[17] = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0}; // release, ptr=2
    vecs[18] = '{4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0}; // search 2,3 -> 3
    vecs[19] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0}; // release, ptr=0
    vecs[20] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0}; // idle

    exp2  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
              4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    exps2 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
              2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

    // Reset state on all builds.
    do_reset();
    check16("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("reset.grant2", 8'(grant2), 8'h00);
    check("reset.grant1", 8'(grant1), 8'h00);

    // MAX_HOLD=2 with all requesting, MAX_HOLD=1 with a sole requester.
    req2 = 4'b1111;
    req1 = 4'b0001;
    for (int c = 0; c < 13; c++) begin
      step();
      check($sformatf("rr2[%0d].grant", c),   8'(grant2), 8'(exp2[c]));
      check($sformatf("rr2[%0d].select", c),  8'(sel2),   8'(exps2[c]));
      check($sformatf("rr2[%0d].timeout", c), 8'(tmo2),   8'((c % 3) == 2));
      check($sformatf("mh1[%0d].grant", c),   8'(grant1), (c % 2 == 0) ? 8'h01 : 8'h00);
      check($sformatf("mh1[%0d].timeout", c), 8'(tmo1),   8'((c % 2) == 1));
      check($sformatf("mh1[%0d].busy", c),    8'(busy1),  8'((c % 2) == 0));
    end

    // Vector table on the default build.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      req16 = vecs[i].req;
      step();
      check16($sformatf("vec[%0d]", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].tmo);
    end

    // Tenure of exactly 16 cycles, one-cycle timeout, then regrant.
    req16 = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      step();
      check16($sformatf("hold[%0d]", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    check16("hold.limit", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    check16("hold.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release on the very cycle the limit is reached still reports timeout.
    for (int k = 2; k <= 16; k++) step();
    req16 = 4'b0000;
    step();
    check16("limit_release", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    check16("limit_release.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Async reset in the middle of a tenure.
    req16 = 4'b0010;
    step();
    check16("pre_reset", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    check16("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    step();
    check16("post_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's 4:1 single-bit mux among four requesters.
- Registers a one-hot grant and drives the mux's 2-bit select.
- Holds a grant while its request stays asserted, up to a bounded tenure.
- Inserts one turnaround cycle between owners so the shared output never switches mid-cycle between two active owners.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 1..255.
- CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  request vector; bit i = requester i wants the mux
- grant  output  4  registered one-hot grant; all-zero when no owner
- select  output  2  registered mux select; binary index of current or last owner
- busy  output  1  registered; high while grant is non-zero
- timeout  output  1  registered one-cycle pulse when a tenure is force-ended at MAX_HOLD

Behaviour:
- Reset (async assert, sync release at clk edge):
  - grant=0, select=0, busy=0, timeout=0.
  - State IDLE, priority pointer ptr=0, hold counter cnt=0.
- States:
  - IDLE: no owner.
    - If req!=0, pick the first set bit searching ptr, ptr+1, ... mod 4.
    - Next cycle: grant=onehot(pick), select=pick, busy=1, cnt=1 -> GRANT.
    - Latency: request sampled at edge N, grant visible after edge N+1 (1 cycle).
  - GRANT: owner o.
    - If req[o]=0: grant=0, busy=0, ptr=o+1 mod 4 -> GAP.
    - Else if cnt==MAX_HOLD: same as the release case, plus timeout=1 for exactly one cycle.
    - Else cnt=cnt+1 and stay.
    - Tenure is exactly MAX_HOLD cycles when req is held continuously.
  - GAP: one mandatory cycle with grant=0, busy=0, select unchanged.
    - Arbitrate from the updated ptr exactly as IDLE does.
    - Next edge goes to GRANT (if any req) or IDLE.
    - Minimum owner-to-owner gap is one cycle.
- select:
  - Updates only when a new grant is issued.
  - Holds the last owner's index in IDLE and GAP.
- Changes to requests other than the owner's during GRANT are ignored; no preemption.
- The owner deasserting and reasserting req in the same GRANT cycle is not visible; only the sampled level counts.
- The same requester re-requesting after release is granted only if no higher round-robin candidate is requesting.
  - Sole requester: regranted after the GAP cycle.
- Simultaneous release and MAX_HOLD: treat as timeout (timeout=1).
- Reset asserted mid-tenure: grant drops immediately (async), ptr returns to 0.
- cnt saturates logic-wise at MAX_HOLD and never wraps.
- No combinational path from req to any output.

Decomposition:
- Package mux4_arb_pkg:
  - N_REQ=4, SEL_W=2.
  - State enum {IDLE, GRANT, GAP}.
  - Function onehot4(sel) returning 4-bit one-hot.
- One combinational sub-module rr_pick4:
  - Inputs req[3:0], ptr[1:0].
  - Outputs found, idx[1:0].
  - Rotate, priority-encode, un-rotate.
- The arbiter top instantiates rr_pick4 once. It does not instantiate the mux; the parent wires select into it.

Test Plan:
- Reset: assert reset mid-GRANT with req=4'b0010 -> grant=0, busy=0, select=0 immediately; after release with req=4'b0010, grant=4'b0010 and select=1 one cycle later.
- Single requester: req=4'b0100 held 3 cycles then dropped -> grant=4'b0100 for 3 cycles, select=2, then 1 GAP cycle with grant=0.
- Round-robin: req=4'b1111 held, MAX_HOLD=2 -> grant sequence 0001,0001,0,0010,0010,0,0100,0100,0,1000,1000,0,0001…; timeout pulses after every tenure.
- Timeout boundary: MAX_HOLD=1, req=4'b0001 held -> grant alternates 0001/0000 every cycle; timeout=1 in each GAP cycle.
- Priority vs pointer: owner 2 releases while req=4'b0101 -> next grant=4'b0001 (ptr=3, search 3,0); select=0.
- No preemption: owner 0 holding, req switches to 4'b1001 -> grant stays 4'b0001 until req[0] drops, then 4'b1000 after GAP.
